flag_ctrl: RTL and testbench

Controller for the Z/N/V flag register in the execute stage of the 16-bit pipelined CPU. It decodes the EX opcode into per-flag write enables and holds the architectural flags. It evaluates the 3-bit branch condition for the branch in ID and resolves the EX-to-ID flag hazard, by stalling or forwarding. It also freezes flag state after HLT retires.

---
 rtl/flag_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_flag_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_ctrl.sv
// flag_ctrl
// ---------------------------------------------------------------------------
// Z/N/V flag controller for the execute stage of the 16-bit pipelined CPU.
// It decodes the EX opcode into per-flag write enables and holds the
// architectural flags. It resolves the 3-bit branch condition for the branch
// sitting in ID. When that branch depends on a flag-setting instruction that
// is still in EX, it either stalls ID for one cycle or forwards the ALU
// result. Once HLT retires, the flag state is frozen until reset.
//
// Optional feature macro: FLAG_FWD_EN
//   defined   : the flag hazard is resolved by forwarding the alu_* values.
//               flag_stall is always 0 and stall_cnt stays 0.
//   undefined : the flag hazard is resolved by a one-cycle ID stall.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ex_valid          EX stage holds a real instruction
//   ex_opcode[3:0]    EX-stage opcode
//   alu_z/alu_n/alu_v ALU flag results for the EX instruction
//   stall_in          global pipeline hold; EX does not retire this cycle
//   flush             ID/EX squash
//   id_valid          ID stage holds a real instruction
//   id_opcode[3:0]    ID-stage opcode
//   id_ccc[2:0]       branch condition code of the ID branch
//   en_z/en_n/en_v    per-flag write enables
//   flag_z/n/v        architectural flags
//   br_valid          the branch in ID is resolved this cycle
//   br_taken          branch condition is true (qualified by br_valid)
//   flag_stall        request a one-cycle ID hold for a flag hazard
//   halted            HLT has retired
//   stall_cnt         saturating count of cycles with flag_stall=1
// ---------------------------------------------------------------------------
module flag_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_ccc,
  output logic             en_z,
  output logic             en_n,
  output logic             en_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             br_valid,
  output logic             br_taken,
  output logic             flag_stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B0  = 4'b1100;
  localparam logic [3:0] OP_B1  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state;
  state_t state_nxt;

  logic sets_z;
  logic sets_nv;
  logic ret;
  logic is_br;
  logic is_hlt;
  logic f_z;
  logic f_n;
  logic f_v;

  // Evaluate a 3-bit branch condition against a set of flag values.
  function automatic logic cond_true(input logic [2:0] ccc,
                                     input logic z, input logic n, input logic v);
    logic res;
    case (ccc)
      3'b000:  res = ~z;
      3'b001:  res = z;
      3'b010:  res = ~z & ~n;
      3'b011:  res = n;
      3'b100:  res = z | (~z & ~n);
      3'b101:  res = n | z;
      3'b110:  res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Opcode classes that write flags. Arithmetic ops write all three flags;
  // logic and shift ops only write Z.
  always_comb begin
    sets_z  = 1'b0;
    sets_nv = 1'b0;
    case (ex_opcode)
      OP_ADD, OP_SUB: begin
        sets_z  = 1'b1;
        sets_nv = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: sets_z = 1'b1;
      default: ;
    endcase
  end

  // An EX instruction only retires when it is real, not held, and the core
  // has not halted. HLT belongs to no flag-setting class, so it never enables
  // a flag write and never creates a hazard.
  assign ret    = ex_valid & ~stall_in & (state != S_HALT);
  assign en_z   = ret & sets_z;
  assign en_n   = ret & sets_nv;
  assign en_v   = ret & sets_nv;
  assign is_br  = id_valid & ((id_opcode == OP_B0) | (id_opcode == OP_B1));
  assign is_hlt = ret & (ex_opcode == OP_HLT);
  assign halted = (state == S_HALT);

`ifdef FLAG_FWD_EN
  // Forward the ALU result for each flag the EX instruction will write,
  // even if EX is currently held.
  assign f_z = (ex_valid & sets_z)  ? alu_z : flag_z;
  assign f_n = (ex_valid & sets_nv) ? alu_n : flag_n;
  assign f_v = (ex_valid & sets_nv) ? alu_v : flag_v;
`else
  logic hazard;
  assign hazard = is_br & ex_valid & sets_z;
  assign f_z    = flag_z;
  assign f_n    = flag_n;
  assign f_v    = flag_v;
`endif

  // Next state and branch/stall outputs. HLT retiring overrides every other
  // transition. A flush suppresses both the stall and the branch result.
  always_comb begin
    state_nxt  = state;
    br_valid   = 1'b0;
    flag_stall = 1'b0;
    case (state)
      S_RUN: begin
`ifdef FLAG_FWD_EN
        br_valid = is_br & ~flush;
`else
        if (hazard & ~flush) begin
          flag_stall = 1'b1;
          if (!stall_in) begin
            state_nxt = S_WAIT;
          end
        end else begin
          br_valid = is_br & ~flush;
        end
`endif
      end
      S_WAIT: begin
        br_valid  = is_br & ~flush;
        state_nxt = S_RUN;
      end
      S_HALT: ;
      default: state_nxt = S_RUN;
    endcase
    if (is_hlt) begin
      state_nxt = S_HALT;
    end
  end

  assign br_taken = br_valid & cond_true(id_ccc, f_z, f_n, f_v);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Architectural flags: each flag loads its ALU value only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      if (en_z) flag_z <= alu_z;
      if (en_n) flag_n <= alu_n;
      if (en_v) flag_v <= alu_v;
    end
  end

  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (flag_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl
// ---------------------------------------------------------------------------
// Bench for flag_ctrl. Directed scenarios cover reset, flag updates, the
// flag hazard (with and without stall_in), counter saturation and halt.
// These are followed by randomized traffic. A behavioural model of the flag
// controller predicts every output on every cycle. It follows the same
// FLAG_FWD_EN build option as the design.
// ---------------------------------------------------------------------------
module tb_flag_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                ex_valid;
  logic [3:0]          ex_opcode;
  logic                alu_z;
  logic                alu_n;
  logic                alu_v;
  logic                stall_in;
  logic                flush;
  logic                id_valid;
  logic [3:0]          id_opcode;
  logic [2:0]          id_ccc;
  logic                en_z;
  logic                en_n;
  logic                en_v;
  logic                flag_z;
  logic                flag_n;
  logic                flag_v;
  logic                br_valid;
  logic                br_taken;
  logic                flag_stall;
  logic                halted;
  logic [TB_CNT_W-1:0] stall_cnt;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // Model state: current values, and the values staged for the next edge.
  bit mZ, mN, mV, mHalted, mPostStall;
  int mCnt;
  bit nZ, nN, nV, nHalted, nPostStall;
  int nCnt;

  flag_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_v      (alu_v),
    .stall_in   (stall_in),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_ccc     (id_ccc),
    .en_z       (en_z),
    .en_n       (en_n),
    .en_v       (en_v),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .flag_stall (flag_stall),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural meaning of each branch condition code.
  function automatic bit condHolds(input bit [2:0] ccc, input bit z, input bit n,
                                   input bit v);
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle of inputs, compare every output against the model,
  // and stage the model's state for the next edge.
  task automatic applyStimulus(input bit r, input bit exv, input bit [3:0] exop,
                               input bit az, input bit an, input bit av,
                               input bit stl, input bit fl, input bit idv,
                               input bit [3:0] idop, input bit [2:0] ccc);
    bit setsZ, setsAll, retire, isBr, haz, fz, fn, fv, xBv, xFs, xBt;
    rst = r; ex_valid = exv; ex_opcode = exop; alu_z = az; alu_n = an; alu_v = av;
    stall_in = stl; flush = fl; id_valid = idv; id_opcode = idop; id_ccc = ccc;
    #1;
    setsZ   = exop inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    setsAll = exop inside {4'd0, 4'd1};
    retire  = exv && !stl && !mHalted;
    isBr    = idv && (idop == 4'd12 || idop == 4'd13);
    haz     = isBr && exv && setsZ;
    fz = (FWD && exv && setsZ)   ? az : mZ;
    fn = (FWD && exv && setsAll) ? an : mN;
    fv = (FWD && exv && setsAll) ? av : mV;
    xBv = 1'b0;
    xFs = 1'b0;
    if (mHalted) begin
      xBv = 1'b0;
    end else if (FWD || mPostStall) begin
      xBv = isBr && !fl;
    end else if (haz && !fl) begin
      xFs = 1'b1;
    end else begin
      xBv = isBr && !fl;
    end
    xBt = xBv && condHolds(ccc, fz, fn, fv);
    if (checkEn) begin
      checkOutput("en_z", en_z, retire && setsZ);
      checkOutput("en_n", en_n, retire && setsAll);
      checkOutput("en_v", en_v, retire && setsAll);
      checkOutput("flag_z", flag_z, mZ);
      checkOutput("flag_n", flag_n, mN);
      checkOutput("flag_v", flag_v, mV);
      checkOutput("br_valid", br_valid, xBv);
      checkOutput("br_taken", br_taken, xBt);
      checkOutput("flag_stall", flag_stall, xFs);
      checkOutput("halted", halted, mHalted);
      checkOutput("stall_cnt", stall_cnt, mCnt);
    end
    if (r) begin
      {nZ, nN, nV, nHalted, nPostStall} = '0;
      nCnt = 0;
    end else begin
      nZ = (retire && setsZ)   ? az : mZ;
      nN = (retire && setsAll) ? an : mN;
      nV = (retire && setsAll) ? av : mV;
      nCnt = (xFs && mCnt < CNT_MAX) ? mCnt + 1 : mCnt;
      nHalted = mHalted || (retire && exop == 4'd15);
      nPostStall = xFs && !stl && !nHalted;
    end
  endtask

  // Advance one clock edge and commit the staged model state.
  task automatic tick();
    @(posedge clk);
    #1;
    mZ = nZ; mN = nN; mV = nV; mHalted = nHalted; mPostStall = nPostStall; mCnt = nCnt;
  endtask

  task automatic idleCycle(input bit r);
    applyStimulus(r, 0, 4'd8, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0);
    tick();
  endtask

  initial begin
    bit [3:0] op;
    {mZ, mN, mV, mHalted, mPostStall} = '0;
    mCnt = 0;
    @(posedge clk);
    #1;

    // 1. Reset with junk on the inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 4'($urandom), 1, 1, 1, 0, 0, 1, 4'd12, 3'd7);
      tick();
    end
    checkEn = 1'b1;
    applyStimulus(0, 0, 4'd8, 1, 1, 1, 0, 0, 0, 4'd0, 3'd0);
    checkOutput("rst_flags", {flag_z, flag_n, flag_v}, 3'b000);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_cnt", stall_cnt, 0);
    checkOutput("rst_brv", br_valid, 0);
    tick();

    // 2. Flag updates.
    applyStimulus(0, 1, 4'd0, 0, 1, 1, 0, 0, 0, 4'd0, 3'd0);
    tick();
    checkOutput("t2_add", {flag_z, flag_n, flag_v}, 3'b011);
    applyStimulus(0, 1, 4'd2, 1, 0, 0, 0, 0, 0, 4'd0, 3'd0);
    tick();
    checkOutput("t2_xor", {flag_z, flag_n, flag_v}, 3'b111);
    applyStimulus(0, 1, 4'd8, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0);
    checkOutput("t2_lw_en", {en_z, en_n, en_v}, 3'b000);
    tick();

    // 3/4. SUB in EX with z=1 and a BZ-style branch in ID.
    applyStimulus(0, 1, 4'd1, 1, 0, 0, 0, 0, 1, 4'd12, 3'd1);
    checkOutput("t3_c0_stall", flag_stall, !FWD);
    checkOutput("t3_c0_brv", br_valid, FWD);
    checkOutput("t3_c0_brt", br_taken, FWD);
    tick();
    applyStimulus(0, 0, 4'd8, 0, 0, 0, 0, 0, 1, 4'd12, 3'd1);
    checkOutput("t3_c1_brv", br_valid, 1);
    checkOutput("t3_c1_brt", br_taken, 1);
    checkOutput("t3_cnt", stall_cnt, FWD ? 0 : 1);
    tick();

    // 5. Hazard held by stall_in for 3 cycles, then released.
    idleCycle(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 4'd0, 0, 1, 1, (i < 3), 0, 1, 4'd13, 3'd3);
      checkOutput("t5_stall", flag_stall, !FWD);
      checkOutput("t5_brv", br_valid, FWD);
      checkOutput("t5_flag_n", flag_n, 0);
      tick();
    end
    applyStimulus(0, 0, 4'd8, 0, 0, 0, 0, 0, 1, 4'd13, 3'd3);
    checkOutput("t5_flags", {flag_z, flag_n, flag_v}, 3'b011);
    checkOutput("t5_cnt", stall_cnt, FWD ? 0 : 4);
    checkOutput("t5_brt", br_taken, 1);
    tick();

    // Counter saturation: long hazard held by stall_in.
    idleCycle(1);
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      applyStimulus(0, 1, 4'd5, 1, 0, 0, 1, 0, 1, 4'd12, 3'd0);
      tick();
    end
    applyStimulus(0, 0, 4'd8, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0);
    checkOutput("sat_cnt", stall_cnt, FWD ? 0 : CNT_MAX);
    tick();

    // 6. Halt freezes flags and suppresses branches until reset.
    idleCycle(1);
    applyStimulus(0, 1, 4'd15, 1, 1, 1, 0, 0, 0, 4'd0, 3'd0);
    checkOutput("t6_hlt_en", {en_z, en_n, en_v}, 3'b000);
    tick();
    checkOutput("t6_halted", halted, 1);
    applyStimulus(0, 1, 4'd0, 1, 1, 1, 0, 0, 1, 4'd13, 3'd7);
    checkOutput("t6_brv", br_valid, 0);
    checkOutput("t6_en", {en_z, en_n, en_v}, 3'b000);
    tick();
    checkOutput("t6_flags", {flag_z, flag_n, flag_v}, 3'b000);
    idleCycle(1);
    applyStimulus(0, 0, 4'd8, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0);
    checkOutput("t6_unhalt", halted, 0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) op = 4'd15;
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), op,
                    1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) != 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom),
                    3'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
